// File: rtl/bin_to_bcd_seq.sv
// Purpose : sequential binary-to-packed-BCD converter (shift-and-add-3, one bit per clock).
// Latency : start accepted at edge N -> bcd_out/overflow/blank update and done pulses at edge N+WIDTH.
// Backpr. : start ignored while busy; accepted in IDLE or in the DONE cycle (back-to-back).
// Option  : define BLANK_LEADING_EN to drive the leading-zero blanking mask; otherwise blank is 0.
module bin_to_bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow,
    output logic [DIGITS-1:0]     blank
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Add 3 to every digit that is 5 or more; digits are independent, no carry between them.
    function automatic logic [BW-1:0] add3_digits(input logic [BW-1:0] s);
        logic [BW-1:0] r;
        logic [3:0]    d;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            d = s[4*i +: 4];
            r[4*i +: 4] = (d >= 4'd5) ? (d + 4'd3) : d;
        end
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]    scratch_q, scratch_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_acc_q, ovf_acc_d;
    logic [BW-1:0]    bcd_q, bcd_d;
    logic             ovf_q, ovf_d;

    // Datapath values for one shift step, derived from the current scratch/shift registers.
    logic [BW-1:0]    scratch_adj;
    logic [BW-1:0]    scratch_sh;
    logic [WIDTH-1:0] shift_sh;
    logic             carry_out;
    logic             accept;
    logic             load_result;

    // One double-dabble step: correct digits, then shift {scratch, shift} left by one.
    always_comb begin
        scratch_adj = add3_digits(scratch_q);
        carry_out   = scratch_adj[BW-1];
        scratch_sh  = {scratch_adj[BW-2:0], shift_q[WIDTH-1]};
        shift_sh    = {shift_q[WIDTH-2:0], 1'b0};
    end

    // Next-state, scratch update and result load.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        scratch_d   = scratch_q;
        cnt_d       = cnt_q;
        ovf_acc_d   = ovf_acc_q;
        bcd_d       = bcd_q;
        ovf_d       = ovf_q;
        accept      = 1'b0;
        load_result = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                // DONE lasts one cycle; a start seen there restarts immediately.
                if (start) begin
                    accept = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                scratch_d = scratch_sh;
                shift_d   = shift_sh;
                ovf_acc_d = ovf_acc_q | carry_out;
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    load_result = 1'b1;
                    state_d     = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            state_d   = SHIFT;
            shift_d   = bin_in;
            scratch_d = '0;
            ovf_acc_d = 1'b0;
            cnt_d     = '0;
        end

        // The final step's scratch and carry are the result; outputs change only here.
        if (load_result) begin
            bcd_d = scratch_sh;
            ovf_d = ovf_acc_q | carry_out;
        end
    end

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            ovf_acc_q <= ovf_acc_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
        end
    end

`ifdef BLANK_LEADING_EN
    // Leading-zero mask: digit i blanked when it and all higher digits are zero; units never blanked.
    function automatic logic [DIGITS-1:0] lead_zero_mask(input logic [BW-1:0] s, input logic ovf);
        logic [DIGITS-1:0] m;
        logic              all_zero;
        m        = '0;
        all_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            all_zero = all_zero & (s[4*i +: 4] == 4'd0);
            m[i]     = all_zero;
        end
        // An overflowed value has hidden upper digits, so nothing is a leading zero.
        if (ovf) begin
            m = '0;
        end
        return m;
    endfunction

    logic [DIGITS-1:0] blank_q, blank_d;

    // Blank mask is loaded alongside bcd_out and overflow.
    always_comb begin
        blank_d = blank_q;
        if (load_result) begin
            blank_d = lead_zero_mask(scratch_sh, ovf_acc_q | carry_out);
        end
    end

    // Blank mask register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank_q <= '0;
        end else begin
            blank_q <= blank_d;
        end
    end

    assign blank = blank_q;
`else
    assign blank = '0;
`endif

    assign busy     = (state_q == SHIFT);
    assign done     = (state_q == DONE);
    assign bcd_out  = bcd_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: a 5-digit and a 4-digit instance driven by directed vectors.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Expected blank values depend on whether BLANK_LEADING_EN is defined for the build.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst;
    logic        start5, start4;
    logic [15:0] bin5, bin4;
    logic        busy5, busy4, done5, done4, ovf5, ovf4;
    logic [19:0] bcd5;
    logic [15:0] bcd4;
    logic [4:0]  blank5;
    logic [3:0]  blank4;

    int tests = 0;
    int fails = 0;

    bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) dut5 (
        .clk(clk), .rst(rst), .start(start5), .bin_in(bin5),
        .busy(busy5), .done(done5), .bcd_out(bcd5), .overflow(ovf5), .blank(blank5)
    );

    bin_to_bcd_seq #(.WIDTH(16), .DIGITS(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .bin_in(bin4),
        .busy(busy4), .done(done4), .bcd_out(bcd4), .overflow(ovf4), .blank(blank4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int which, input logic s, input logic [15:0] v);
        if (which == 4) begin
            start4 = s;
            bin4   = v;
        end else begin
            start5 = s;
            bin5   = v;
        end
    endtask

    function automatic logic sel_done(input int which);
        return (which == 4) ? done4 : done5;
    endfunction

    function automatic logic sel_busy(input int which);
        return (which == 4) ? busy4 : busy5;
    endfunction

    // launch=0: the start was accepted at the edge just before the current falling edge.
    // inj_k: sample index at which a one-cycle start pulse with inj_v is injected (-1 = none).
    // hold: if >= 0, start is raised with that value one cycle before DONE and held through it.
    task automatic conv(input int which, input bit launch, input logic [15:0] v,
                        input int inj_k, input logic [15:0] inj_v, input int hold,
                        input logic [19:0] exp_bcd, input logic exp_ovf,
                        input logic [4:0] exp_blank, input string tag);
        int k;
        int nb;
        logic [19:0] obs_bcd;
        logic        obs_ovf;
        logic [4:0]  obs_blank;
        logic [4:0]  eb;
        if (launch) begin
            @(negedge clk);
            drive(which, 1'b1, v);
            @(posedge clk);
            #1 drive(which, 1'b0, v);
        end
        nb = 0;
        for (k = 0; k < 40; k++) begin
            if (launch || k > 0) @(negedge clk);
            if (k == inj_k) drive(which, 1'b1, inj_v);
            if (inj_k >= 0 && k == inj_k + 1) drive(which, 1'b0, inj_v);
            if (hold >= 0 && k == 15) drive(which, 1'b1, 16'(hold));
            if (sel_done(which)) break;
            nb += int'(sel_busy(which));
        end
        check({tag, " latency"}, 32'(k), 32'd16);
        check({tag, " busy_cycles"}, 32'(nb), 32'd16);
        if (which == 4) begin
            obs_bcd   = {4'h0, bcd4};
            obs_ovf   = ovf4;
            obs_blank = {1'b0, blank4};
        end else begin
            obs_bcd   = bcd5;
            obs_ovf   = ovf5;
            obs_blank = blank5;
        end
`ifdef BLANK_LEADING_EN
        eb = exp_blank;
`else
        eb = 5'b00000;
`endif
        check({tag, " bcd"}, 32'(obs_bcd), 32'(exp_bcd));
        check({tag, " overflow"}, 32'(obs_ovf), 32'(exp_ovf));
        check({tag, " blank"}, 32'(obs_blank), 32'(eb));
        @(negedge clk);
        check({tag, " done_pulse_end"}, 32'(sel_done(which)), 32'd0);
        if (hold >= 0) begin
            check({tag, " restart_busy"}, 32'(sel_busy(which)), 32'd1);
            drive(which, 1'b0, 16'h0000);
        end else begin
            check({tag, " idle_busy"}, 32'(sel_busy(which)), 32'd0);
        end
    endtask

    initial begin
        int ndone;
        rst    = 1'b1;
        start5 = 1'b0;
        start4 = 1'b0;
        bin5   = '0;
        bin4   = '0;
        #1;
        check("reset busy", 32'(busy5), 32'd0);
        check("reset done", 32'(done5), 32'd0);
        check("reset bcd", 32'(bcd5), 32'd0);
        check("reset overflow", 32'(ovf5), 32'd0);
        check("reset blank", 32'(blank5), 32'd0);
        check("reset bcd4", 32'(bcd4), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Basic conversions on the 5-digit instance.
        conv(5, 1'b1, 16'd0,     -1, 16'd0, -1, 20'h00000, 1'b0, 5'b11110, "zero");
        conv(5, 1'b1, 16'd12345, -1, 16'd0, -1, 20'h12345, 1'b0, 5'b00000, "12345");
        conv(5, 1'b1, 16'hFFFF,  -1, 16'd0, -1, 20'h65535, 1'b0, 5'b00000, "ffff");
        conv(5, 1'b1, 16'd42,    -1, 16'd0, -1, 20'h00042, 1'b0, 5'b11100, "42");
        conv(5, 1'b1, 16'd10000, -1, 16'd0, -1, 20'h10000, 1'b0, 5'b00000, "10000_d5");

        // Overflow boundary on the 4-digit instance.
        conv(4, 1'b1, 16'd10000, -1, 16'd0, -1, 20'h00000, 1'b1, 5'b00000, "d4_10000");
        conv(4, 1'b1, 16'd9999,  -1, 16'd0, -1, 20'h09999, 1'b0, 5'b00000, "d4_9999");
        conv(4, 1'b1, 16'd65535, -1, 16'd0, -1, 20'h05535, 1'b1, 5'b00000, "d4_65535");

        // start pulsed mid-conversion is ignored; then start held through DONE restarts at once.
        conv(5, 1'b1, 16'd321, 5, 16'd7, 42, 20'h00321, 1'b0, 5'b11000, "ignore_321");
        conv(5, 1'b0, 16'd42, -1, 16'd0, -1, 20'h00042, 1'b0, 5'b11100, "b2b_42");

        // Asynchronous reset in the middle of a conversion.
        @(negedge clk);
        start5 = 1'b1;
        bin5   = 16'd999;
        @(posedge clk);
        #1 start5 = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst busy", 32'(busy5), 32'd0);
        check("midrst done", 32'(done5), 32'd0);
        check("midrst bcd", 32'(bcd5), 32'd0);
        check("midrst overflow", 32'(ovf5), 32'd0);
        check("midrst blank", 32'(blank5), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ndone += int'(done5);
        end
        check("midrst no_done", 32'(ndone), 32'd0);
        conv(5, 1'b1, 16'd58, -1, 16'd0, -1, 20'h00058, 1'b0, 5'b11100, "after_rst_58");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
